// File: rtl/ram_access_pkg.sv
// Shared state encoding and address helpers for the single-port RAM access controller.
package ram_access_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

    function automatic int addr_w(input int mem_length);
        return (mem_length > 1) ? $clog2(mem_length) : 1;
    endfunction

    function automatic int len_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

    // Depth need not be a power of two, so the address wraps explicitly.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned mem_length);
        return (addr == mem_length - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Initiator for a one-cycle-latency single-port RAM: single-beat writes, multi-beat
// reads streamed back over a valid/ready response channel with last-beat framing.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32,
    parameter int MAX_BURST   = 8,
    localparam int ADDR_W = addr_w(MEM_LENGTH),
    localparam int LEN_W  = len_w(MAX_BURST)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [DATA_LENGTH-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_LENGTH-1:0] rsp_data,
    output logic                   rsp_last,
    output logic                   busy,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic [DATA_LENGTH-1:0] mem_rdata
);

    state_t                   state_q, state_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_LENGTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_last_q, rsp_last_d;
    logic [DATA_LENGTH-1:0]   rsp_data_q, rsp_data_d;
    logic [LEN_W-1:0]         beats_q, beats_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            beats_q     <= beats_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        beats_d     = beats_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    if (req_we) begin
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                        state_d     = WR;
                    end else begin
                        beats_d  = req_len;
                        mem_we_d = 1'b0;
                        state_d  = RD_ISSUE;
                    end
                end
            end
            WR: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
            // RAM samples mem_addr at the end of this cycle; data is valid in RD_CAPT.
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (beats_q == '0);
                state_d     = RD_RESP;
            end
            RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (beats_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d    = beats_q - LEN_W'(1);
                        mem_addr_d = ADDR_W'(next_addr(32'(mem_addr_q), MEM_LENGTH));
                        state_d    = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;

endmodule
